ext_int_ctrl: RTL and testbench

EXT_INT_CTRL -- requirements
Module: ext_int_ctrl

---
 rtl/ext_int_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ext_int_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: per-source gateways and pending bits, priority/threshold arbitration, claim/complete handshake.
// Build option EXT_INT_CTRL_EDGE_EN selects edge-triggered sources; the default build is level-triggered.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module ext_int_ctrl (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 src_extint_irq,
   output logic                       extint_all_int_ext_req,
   input  logic                       intif_all_int_ext_ack,
   input  logic                       commit_extint_complete,
   output logic [2:0]                 extint_commit_claim_id,
   output logic                       extint_commit_claim_valid,
   input  logic                       csrf_extint_we,
   input  logic [3:0]                 csrf_extint_addr,
   input  logic [`REG_DATA_WIDTH-1:0] csrf_extint_wdata,
   output logic [`REG_DATA_WIDTH-1:0] extint_csrf_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t     state_q, state_d;
   logic [2:0] prio_q [8];
   logic [7:0] enable_q;
   logic [2:0] threshold_q;
   logic [7:0] pend_q, pend_d;
   logic [2:0] claim_id_q, claim_id_d;

   logic       win_vld;
   logic [2:0] win_id;
   logic [2:0] win_prio;
   logic       claim_fire;
   logic       done_fire;
   logic [7:0] claim_hit;
   logic [7:0] gate_open;
   logic [7:0] clr;
   logic [7:0] reopen;

   logic       unused_wdata;
   assign unused_wdata = ^csrf_extint_wdata[`REG_DATA_WIDTH-1:8];

   // Highest priority wins; strict compare keeps the lowest index on ties.
   always_comb begin
      win_vld  = 1'b0;
      win_id   = '0;
      win_prio = '0;
      for (int i = 0; i < 8; i++) begin
         if (pend_q[i] && enable_q[i] && (prio_q[i] > threshold_q) && (prio_q[i] > win_prio)) begin
            win_vld  = 1'b1;
            win_id   = 3'(i);
            win_prio = prio_q[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         claim_hit[i] = (claim_id_q == 3'(i));
      end
   end

   // Only the source in service has its gateway closed, so the gateway follows the FSM.
   assign gate_open  = ~(claim_hit & {8{state_q == SERVICE}});
   assign extint_all_int_ext_req = (state_q == REQ) && win_vld;
   assign claim_fire = extint_all_int_ext_req && intif_all_int_ext_ack;
   assign done_fire  = (state_q == SERVICE) && commit_extint_complete;
   assign clr        = claim_hit & {8{claim_fire}};
   assign reopen     = claim_hit & {8{done_fire}};

   assign extint_commit_claim_id    = claim_id_q;
   assign extint_commit_claim_valid = (state_q == SERVICE);

   always_comb begin
      state_d    = state_q;
      claim_id_d = claim_id_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d    = REQ;
               claim_id_d = win_id;
            end
         end
         REQ: begin
            // An ack claims the ID latched at the previous edge, even if the winner just moved.
            if (claim_fire) begin
               state_d = SERVICE;
            end else if (!win_vld) begin
               state_d = IDLE;
            end else begin
               claim_id_d = win_id;
            end
         end
         SERVICE: begin
            if (commit_extint_complete) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef EXT_INT_CTRL_EDGE_EN
   logic [7:0] src_prev_q;
   logic [7:0] held_q, held_d;
   logic [7:0] rise;
   logic [7:0] open_now;

   assign rise     = src_extint_irq & ~src_prev_q;
   assign open_now = gate_open & ~clr;

   // Edges seen while the gateway is closed are parked and replayed on completion.
   always_comb begin
      pend_d = (pend_q & ~clr) | (rise & (open_now | reopen)) | (held_q & reopen);
      held_d = (held_q | (rise & ~open_now & ~reopen)) & ~reopen;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_prev_q <= '0;
         held_q     <= '0;
      end else begin
         src_prev_q <= src_extint_irq;
         held_q     <= held_d;
      end
   end
`else
   always_comb begin
      pend_d = (pend_q | (src_extint_irq & gate_open)) & ~clr;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         claim_id_q  <= '0;
         pend_q      <= '0;
         enable_q    <= '0;
         threshold_q <= '0;
         for (int i = 0; i < 8; i++) begin
            prio_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         claim_id_q <= claim_id_d;
         pend_q     <= pend_d;
         if (csrf_extint_we) begin
            if (!csrf_extint_addr[3]) begin
               prio_q[csrf_extint_addr[2:0]] <= csrf_extint_wdata[2:0];
            end else if (csrf_extint_addr == 4'd8) begin
               enable_q <= csrf_extint_wdata[7:0];
            end else if (csrf_extint_addr == 4'd9) begin
               threshold_q <= csrf_extint_wdata[2:0];
            end
         end
      end
   end

   always_comb begin
      extint_csrf_rdata = '0;
      if (!csrf_extint_addr[3]) begin
         extint_csrf_rdata[2:0] = prio_q[csrf_extint_addr[2:0]];
      end else if (csrf_extint_addr == 4'd8) begin
         extint_csrf_rdata[7:0] = enable_q;
      end else if (csrf_extint_addr == 4'd9) begin
         extint_csrf_rdata[2:0] = threshold_q;
      end
   end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Self-checking bench for ext_int_ctrl: register table plus claim-order scenarios checked through an expected-ID queue.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module tb_ext_int_ctrl;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [7:0]                 src_extint_irq;
   logic                       extint_all_int_ext_req;
   logic                       intif_all_int_ext_ack;
   logic                       commit_extint_complete;
   logic [2:0]                 extint_commit_claim_id;
   logic                       extint_commit_claim_valid;
   logic                       csrf_extint_we;
   logic [3:0]                 csrf_extint_addr;
   logic [`REG_DATA_WIDTH-1:0] csrf_extint_wdata;
   logic [`REG_DATA_WIDTH-1:0] extint_csrf_rdata;

   ext_int_ctrl dut (
      .clk                       (clk),
      .rst                       (rst),
      .src_extint_irq            (src_extint_irq),
      .extint_all_int_ext_req    (extint_all_int_ext_req),
      .intif_all_int_ext_ack     (intif_all_int_ext_ack),
      .commit_extint_complete    (commit_extint_complete),
      .extint_commit_claim_id    (extint_commit_claim_id),
      .extint_commit_claim_valid (extint_commit_claim_valid),
      .csrf_extint_we            (csrf_extint_we),
      .csrf_extint_addr          (csrf_extint_addr),
      .csrf_extint_wdata         (csrf_extint_wdata),
      .extint_csrf_rdata         (extint_csrf_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [16];
   int   exp_q [$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      src_extint_irq = '0;
      intif_all_int_ext_ack = 1'b0;
      commit_extint_complete = 1'b0;
      csrf_extint_we = 1'b0;
      csrf_extint_addr = '0;
      csrf_extint_wdata = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
      csrf_extint_we = 1'b1;
      csrf_extint_addr = a;
      csrf_extint_wdata = `REG_DATA_WIDTH'(d);
      step();
      csrf_extint_we = 1'b0;
      csrf_extint_addr = '0;
   endtask

   task automatic wait_req(input string nm);
      int n = 0;
      while (!extint_all_int_ext_req && n < 20) begin
         step();
         n++;
      end
      if (!extint_all_int_ext_req) begin
         n_total++;
         $display("FAIL %s: ext_req not seen within 20 cycles, required 1", nm);
      end
   endtask

   function automatic int pop_exp(input string nm);
      if (exp_q.size() == 0) begin
         $display("FAIL %s: scoreboard empty", nm);
         return -1;
      end
      return exp_q.pop_front();
   endfunction

   // Wait for a request, compare ID against the scoreboard, then claim and complete it.
   task automatic serve(input string nm);
      int e;
      wait_req(nm);
      e = pop_exp(nm);
      chk({nm, "_id"}, 32'(extint_commit_claim_id), 32'(e));
      intif_all_int_ext_ack = 1'b1;
      step();
      intif_all_int_ext_ack = 1'b0;
      chk({nm, "_valid"}, 32'(extint_commit_claim_valid), 32'd1);
      chk({nm, "_req_svc"}, 32'(extint_all_int_ext_req), 32'd0);
      step();
      chk({nm, "_req_svc2"}, 32'(extint_all_int_ext_req), 32'd0);
      chk({nm, "_id_svc"}, 32'(extint_commit_claim_id), 32'(e));
      commit_extint_complete = 1'b1;
      step();
      commit_extint_complete = 1'b0;
      chk({nm, "_valid_done"}, 32'(extint_commit_claim_valid), 32'd0);
      chk({nm, "_req_idle"}, 32'(extint_all_int_ext_req), 32'd0);
   endtask

   initial begin
      int saw;

      tbl[0]  = '{4'd0,  32'hFFFF_FFFD, 32'h5};
      tbl[1]  = '{4'd1,  32'h0000_000A, 32'h2};
      tbl[2]  = '{4'd2,  32'h1234_5677, 32'h7};
      tbl[3]  = '{4'd3,  32'h8000_0003, 32'h3};
      tbl[4]  = '{4'd4,  32'h0000_00F4, 32'h4};
      tbl[5]  = '{4'd5,  32'h0000_0009, 32'h1};
      tbl[6]  = '{4'd6,  32'hFFFF_FFF0, 32'h0};
      tbl[7]  = '{4'd7,  32'h0000_0006, 32'h6};
      tbl[8]  = '{4'd8,  32'hFFFF_FFA5, 32'hA5};
      tbl[9]  = '{4'd9,  32'h0000_00FE, 32'h6};
      tbl[10] = '{4'd10, 32'hFFFF_FFFF, 32'h0};
      tbl[11] = '{4'd11, 32'h0000_1234, 32'h0};
      tbl[12] = '{4'd12, 32'hFFFF_FFFF, 32'h0};
      tbl[13] = '{4'd13, 32'hFFFF_FFFF, 32'h0};
      tbl[14] = '{4'd14, 32'hFFFF_FFFF, 32'h0};
      tbl[15] = '{4'd15, 32'hFFFF_FFFF, 32'h0};

      // Reset state
      do_reset();
      chk("rst_req", 32'(extint_all_int_ext_req), 32'd0);
      chk("rst_id", 32'(extint_commit_claim_id), 32'd0);
      chk("rst_valid", 32'(extint_commit_claim_valid), 32'd0);
      for (int a = 0; a < 10; a++) begin
         csrf_extint_addr = 4'(a);
         #1;
         chk($sformatf("rst_rd%0d", a), 32'(extint_csrf_rdata), 32'd0);
      end

      // Register write masking and read-back table
      for (int i = 0; i < 16; i++) cfg_wr(tbl[i].addr, tbl[i].wdata);
      for (int i = 0; i < 16; i++) begin
         csrf_extint_addr = tbl[i].addr;
         #1;
         chk($sformatf("reg_rd%0d", i), 32'(extint_csrf_rdata), tbl[i].exp);
      end

      // Single source: latency, claim, complete
      do_reset();
      cfg_wr(4'd3, 32'd2);
      cfg_wr(4'd8, 32'h08);
      cfg_wr(4'd9, 32'd0);
      src_extint_irq = 8'h08;
      step();
      chk("lat_k_req", 32'(extint_all_int_ext_req), 32'd0);
      step();
      chk("lat_k1_req", 32'(extint_all_int_ext_req), 32'd1);
      chk("lat_k1_id", 32'(extint_commit_claim_id), 32'd3);
      src_extint_irq = 8'h00;
      exp_q.push_back(3);
      serve("single");
      step();
      chk("single_idle_req", 32'(extint_all_int_ext_req), 32'd0);

      // Priority order with a tie; sources pulsed once so pending must persist
      do_reset();
      cfg_wr(4'd1, 32'd5);
      cfg_wr(4'd6, 32'd5);
      cfg_wr(4'd2, 32'd7);
      cfg_wr(4'd8, 32'hFF);
      src_extint_irq = 8'h46;
      step();
      src_extint_irq = 8'h00;
      exp_q.push_back(2);
      exp_q.push_back(1);
      exp_q.push_back(6);
      serve("order_a");
      step();
      chk("order_idle_gap_req", 32'(extint_all_int_ext_req), 32'd1);
      serve("order_b");
      serve("order_c");
      step();
      chk("order_drained", 32'(extint_all_int_ext_req), 32'd0);

      // Threshold masking then lowering
      do_reset();
      cfg_wr(4'd4, 32'd3);
      cfg_wr(4'd9, 32'd3);
      cfg_wr(4'd8, 32'h10);
      src_extint_irq = 8'h10;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("thr_masked%0d", i), 32'(extint_all_int_ext_req), 32'd0);
      end
      cfg_wr(4'd9, 32'd2);
      chk("thr_after_wr", 32'(extint_all_int_ext_req), 32'd0);
      step();
      chk("thr_req", 32'(extint_all_int_ext_req), 32'd1);
      chk("thr_id", 32'(extint_commit_claim_id), 32'd4);

      // Disable the winner while requesting, then hold the source through claim
      do_reset();
      cfg_wr(4'd5, 32'd4);
      cfg_wr(4'd8, 32'h20);
      src_extint_irq = 8'h20;
      wait_req("dis_wait");
      chk("dis_id", 32'(extint_commit_claim_id), 32'd5);
      cfg_wr(4'd8, 32'h00);
      chk("dis_req_drop", 32'(extint_all_int_ext_req), 32'd0);
      step();
      chk("dis_req_idle", 32'(extint_all_int_ext_req), 32'd0);
      cfg_wr(4'd8, 32'h20);
      exp_q.push_back(5);
      serve("dis_serve");
      saw = 0;
      for (int i = 0; i < 6; i++) begin
         if (extint_all_int_ext_req) saw = 1;
         step();
      end
`ifdef EXT_INT_CTRL_EDGE_EN
      chk("dis_no_rereq", 32'(saw), 32'd0);
`else
      chk("dis_rereq", 32'(saw), 32'd1);
      chk("dis_rereq_id", 32'(extint_commit_claim_id), 32'd5);
`endif

      // Ignored handshakes and ack racing a winner change
      do_reset();
      cfg_wr(4'd1, 32'd3);
      cfg_wr(4'd2, 32'd6);
      cfg_wr(4'd8, 32'h06);
      intif_all_int_ext_ack = 1'b1;
      step();
      intif_all_int_ext_ack = 1'b0;
      chk("ack_idle_ignored", 32'(extint_commit_claim_valid), 32'd0);
      src_extint_irq = 8'h02;
      step();
      src_extint_irq = 8'h00;
      exp_q.push_back(1);
      exp_q.push_back(2);
      wait_req("race_wait");
      commit_extint_complete = 1'b1;
      step();
      commit_extint_complete = 1'b0;
      chk("cmp_req_ignored_req", 32'(extint_all_int_ext_req), 32'd1);
      chk("cmp_req_ignored_valid", 32'(extint_commit_claim_valid), 32'd0);
      src_extint_irq = 8'h04;
      step();
      src_extint_irq = 8'h00;
      saw = pop_exp("race_pop");
      chk("race_id_before_ack", 32'(extint_commit_claim_id), 32'(saw));
      intif_all_int_ext_ack = 1'b1;
      step();
      intif_all_int_ext_ack = 1'b0;
      chk("race_valid", 32'(extint_commit_claim_valid), 32'd1);
      chk("race_claimed_id", 32'(extint_commit_claim_id), 32'(saw));
      commit_extint_complete = 1'b1;
      step();
      commit_extint_complete = 1'b0;
      chk("race_idle", 32'(extint_all_int_ext_req), 32'd0);
      serve("race_next");

      // Reset during service abandons the claim
      do_reset();
      cfg_wr(4'd0, 32'd1);
      cfg_wr(4'd8, 32'h01);
      src_extint_irq = 8'h01;
      step();
      src_extint_irq = 8'h00;
      wait_req("rsvc_wait");
      intif_all_int_ext_ack = 1'b1;
      step();
      intif_all_int_ext_ack = 1'b0;
      chk("rsvc_in_service", 32'(extint_commit_claim_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rsvc_req", 32'(extint_all_int_ext_req), 32'd0);
      chk("rsvc_valid", 32'(extint_commit_claim_valid), 32'd0);
      chk("rsvc_id", 32'(extint_commit_claim_id), 32'd0);
      commit_extint_complete = 1'b1;
      step();
      commit_extint_complete = 1'b0;
      step();
      chk("rsvc_cmp_req", 32'(extint_all_int_ext_req), 32'd0);
      chk("rsvc_cmp_valid", 32'(extint_commit_claim_valid), 32'd0);
      csrf_extint_addr = 4'd8;
      #1;
      chk("rsvc_enable_cleared", 32'(extint_csrf_rdata), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
